// File: rtl/fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit_if                                                |
// | Description : Instruction-memory fetch bus. A request is held with a       |
// |               stable address until the memory returns a one-cycle ack      |
// |               pulse together with the instruction word.                    |
// | Ports       : inst_req   - fetch request (master -> slave)                 |
// |               inst_addr  - word-aligned fetch address (master -> slave)    |
// |               inst_ack   - one-cycle response pulse (slave -> master)      |
// |               inst_rdata - instruction word, valid with ack (slave->master)|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ack,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ack,
    output inst_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction-fetch stage plus IF/ID pipeline register. Owns   |
// |               the PC, runs the req/ack handshake to instruction memory,    |
// |               parks responses that arrive while ID is stalled and throws   |
// |               away responses to fetches made obsolete by a redirect.       |
// | Macro       : FETCH_PERF_EN - adds perf_fetched/perf_stall/perf_squash     |
// | Ports       : clk, reset         - clock, synchronous active-high reset    |
// |               Stall              - hold PC and IF/ID                       |
// |               IF_Flush           - squash the instruction in IF            |
// |               ID_PCSrc           - 00 seq, 01 branch, 10 jr, 11 j/jal      |
// |               ID_*_target        - redirect targets                        |
// |               mem                - fetch bus (fetch_unit_if.master)        |
// |               ID_Instruction/PC  - IF/ID register contents                |
// |               ID_Valid           - IF/ID holds a real instruction          |
// |               perf_*             - event counters (FETCH_PERF_EN only)     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        Stall,
  input  wire logic        IF_Flush,
  input  wire logic [1:0]  ID_PCSrc,
  input  wire logic [31:0] ID_Branch_target,
  input  wire logic [31:0] ID_Jr_target,
  input  wire logic [31:0] ID_Jump_target,
  fetch_unit_if.master     mem,
  output logic [31:0]      ID_Instruction,
  output logic [31:0]      ID_PC,
  output logic             ID_Valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_squash
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding for pc_q
    S_HOLD  = 2'd1,  // response parked in buf_q, no request
    S_DROP  = 2'd2   // request for stale pc_q outstanding, tgt_q is next pc
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] buf_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        id_valid_q;

  logic        w_arrive;
  logic [31:0] w_word;
  logic        w_redirect;
  logic [31:0] w_target;

  // A word is available this cycle either straight from memory or from the
  // parking buffer filled during an earlier stall.
  assign w_arrive   = ((state_q == S_FETCH) && mem.inst_ack) || (state_q == S_HOLD);
  assign w_word     = (state_q == S_HOLD) ? buf_q : mem.inst_rdata;
  assign w_redirect = !Stall && ((ID_PCSrc != 2'b00) || IF_Flush);

  // A flush with sequential PCSrc resynchronises to the instruction after
  // the one sitting in ID. Low address bits are forced to keep fetches aligned.
  always_comb begin
    w_target = id_pc_q + 32'd4;
    case (ID_PCSrc)
      2'b01:   w_target = ID_Branch_target;
      2'b10:   w_target = ID_Jr_target;
      2'b11:   w_target = ID_Jump_target;
      default: w_target = id_pc_q + 32'd4;
    endcase
    w_target[1:0] = 2'b00;
  end

  // Request is decoded from registered state only; reset masks it so the
  // memory sees no request while reset is held.
  assign mem.inst_req  = !reset && (state_q != S_HOLD);
  assign mem.inst_addr = pc_q;

  assign ID_Instruction = id_instr_q;
  assign ID_PC          = id_pc_q;
  assign ID_Valid       = id_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'd0;
      buf_q      <= NOP;
      id_instr_q <= NOP;
      id_pc_q    <= 32'd0;
      id_valid_q <= 1'b0;
    end else if (Stall) begin
      // IF/ID and pc hold; only the memory side keeps moving.
      case (state_q)
        S_FETCH: begin
          if (mem.inst_ack) begin
            buf_q   <= mem.inst_rdata;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          state_q <= S_HOLD;
        end
        S_DROP: begin
          // The stale response must still be consumed; loading the pending
          // redirect target is not a sequential advance.
          if (mem.inst_ack) begin
            pc_q    <= tgt_q;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end else if (w_redirect) begin
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (mem.inst_ack) begin
            pc_q    <= w_target;
            state_q <= S_FETCH;
          end else begin
            tgt_q   <= w_target;
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          pc_q    <= w_target;
          state_q <= S_FETCH;
        end
        S_DROP: begin
          // Newest redirect wins; if the stale ack lands now, go there directly.
          if (mem.inst_ack) begin
            pc_q    <= w_target;
            state_q <= S_FETCH;
          end else begin
            tgt_q   <= w_target;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end else if (w_arrive) begin
      id_instr_q <= w_word;
      id_pc_q    <= pc_q;
      id_valid_q <= 1'b1;
      pc_q       <= pc_q + 32'd4;
      state_q    <= S_FETCH;
    end else begin
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      if ((state_q == S_DROP) && mem.inst_ack) begin
        pc_q    <= tgt_q;
        state_q <= S_FETCH;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_squash_q;
  logic        w_squash;

  // A discarded word is either one arriving under a redirect or the stale
  // response that finally lands in DROP.
  assign w_squash = (w_redirect && w_arrive) || ((state_q == S_DROP) && mem.inst_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
      perf_squash_q  <= 32'd0;
    end else begin
      if ((state_q == S_FETCH) && mem.inst_ack) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (Stall)                                perf_stall_q   <= perf_stall_q + 32'd1;
      if (w_squash)                             perf_squash_q  <= perf_squash_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_squash  = perf_squash_q;
`endif

endmodule

`default_nettype wire
